// File: rtl/vga_pkg.sv
// Shared types and screen constants for the VGA pixel-write path.
package vga_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Screen geometry.
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Pixel field widths.
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

endpackage

// File: rtl/plot_arbiter_if.sv
// Bundle of request/grant and pixel signals between drawing engines and the arbiter.
//
// Handshake: req[i] is a level request that the engine holds until it sees
// ack[i]. Once granted, the arbiter pulses eng_start[i] for one cycle. The
// engine then presents pixels on its eng_* slice, where eng_plot[i] marks a
// valid pixel in that cycle (the VGA port never back-pressures). The engine
// raises eng_done[i] to hand the port back. ack[i] pulses once to close the
// transaction.
interface plot_arbiter_if #(
    parameter int N_REQ = 3
);
    import vga_pkg::*;

    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     ack;
    logic [N_REQ-1:0]     gnt;
    logic [N_REQ-1:0]     eng_start;
    logic [N_REQ-1:0]     eng_done;
    logic [X_W*N_REQ-1:0] eng_x;
    logic [Y_W*N_REQ-1:0] eng_y;
    logic [C_W*N_REQ-1:0] eng_colour;
    logic [N_REQ-1:0]     eng_plot;
    logic [X_W-1:0]       vga_x;
    logic [Y_W-1:0]       vga_y;
    logic [C_W-1:0]       vga_colour;
    logic                 vga_plot;
    logic                 busy;

    // Engine / environment side.
    modport master (
        output req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
        input  ack, gnt, eng_start, vga_x, vga_y, vga_colour, vga_plot, busy
    );

    // Arbiter side.
    modport slave (
        input  req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
        output ack, gnt, eng_start, vga_x, vga_y, vga_colour, vga_plot, busy
    );

endinterface

// File: rtl/plot_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit starting at (last+1) mod N_REQ.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % N_REQ);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin owner of the VGA pixel-write port shared by N_REQ drawing engines.
module plot_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    plot_arbiter_if.slave bus,
    output state_t       state_dbg
);

    state_t           state;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] last;
    logic             found;
    logic [IDX_W-1:0] pick;

    logic [X_W-1:0]   own_x;
    logic [Y_W-1:0]   own_y;
    logic [C_W-1:0]   own_colour;
    logic             own_plot;
    logic             own_done;

    assign state_dbg = state;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .last  (last),
        .found (found),
        .idx   (pick)
    );

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Select the owner's engine slice; non-owners never reach the VGA side.
    always_comb begin
        own_x      = '0;
        own_y      = '0;
        own_colour = '0;
        own_plot   = 1'b0;
        own_done   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == IDX_W'(i)) begin
                own_x      = bus.eng_x[i*X_W +: X_W];
                own_y      = bus.eng_y[i*Y_W +: Y_W];
                own_colour = bus.eng_colour[i*C_W +: C_W];
                own_plot   = bus.eng_plot[i];
                own_done   = bus.eng_done[i];
            end
        end
    end

    // Ownership FSM with registered grant, pulses and pixel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sel            <= '0;
            last           <= IDX_W'(N_REQ - 1);
            bus.gnt        <= '0;
            bus.ack        <= '0;
            bus.eng_start  <= '0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot   <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.ack       <= '0;
            bus.eng_start <= '0;
            bus.vga_plot  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        sel           <= pick;
                        bus.gnt       <= onehot(pick);
                        bus.eng_start <= onehot(pick);
                        bus.busy      <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    state <= BUSY;
                end
                BUSY: begin
                    // The pixel of the done cycle is still forwarded.
                    bus.vga_x      <= own_x;
                    bus.vga_y      <= own_y;
                    bus.vga_colour <= own_colour;
                    bus.vga_plot   <= own_plot;
                    if (own_done) begin
                        bus.gnt <= '0;
                        bus.ack <= onehot(sel);
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    last     <= sel;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter with N_REQ=3.
module tb_plot_arbiter;
    import vga_pkg::*;

    localparam int N = 3;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t state_dbg;

    int checks = 0;
    int errors = 0;

    logic [17:0] exp_q[$];
    bit          covered [SCREEN_W*SCREEN_H];

    // Clock and reset block.
    always #5 clk = ~clk;

    plot_arbiter_if #(.N_REQ(N)) bus ();

    plot_arbiter #(
        .N_REQ (N),
        .IDX_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int i, input int x, input int y, input int c, input logic p);
        bus.eng_x[i*X_W +: X_W]      = X_W'(x);
        bus.eng_y[i*Y_W +: Y_W]      = Y_W'(y);
        bus.eng_colour[i*C_W +: C_W] = C_W'(c);
        bus.eng_plot[i]              = p;
    endtask

    task automatic clear_engines();
        bus.eng_done   = '0;
        bus.eng_x      = '0;
        bus.eng_y      = '0;
        bus.eng_colour = '0;
        bus.eng_plot   = '0;
    endtask

    // Structural invariants on every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($onehot0(bus.gnt) && $onehot0(bus.ack)) else begin
                errors++;
                $error("FAIL onehot: observed gnt=%b ack=%b expected one-hot or zero", bus.gnt, bus.ack);
            end
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int fill_plots;
    int fill_bad;
    int fill_dup;
    int fill_missing;
    int w;
    int o;
    logic [17:0] got;
    logic [17:0] want;
    int idx;

    initial begin
        bus.req = '0;
        clear_engines();

        // Reset state.
        rst = 1'b1;
        step();
        step();
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_start", 32'(bus.eng_start), 32'h0);
        chk("rst_vga_x", 32'(bus.vga_x), 32'h0);
        chk("rst_vga_y", 32'(bus.vga_y), 32'h0);
        chk("rst_vga_col", 32'(bus.vga_colour), 32'h0);
        chk("rst_vga_plot", 32'(bus.vga_plot), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);

        // Single requester 1.
        rst = 1'b0;
        bus.req = 3'b010;
        step();
        chk("t1_state", 32'(state_dbg), 32'(START));
        chk("t1_gnt", 32'(bus.gnt), 32'h2);
        chk("t1_start", 32'(bus.eng_start), 32'h2);
        chk("t1_busy", 32'(bus.busy), 32'h1);
        step();
        chk("t1_busy_state", 32'(state_dbg), 32'(BUSY));
        chk("t1_start_clr", 32'(bus.eng_start), 32'h0);
        chk("t1_gnt_hold", 32'(bus.gnt), 32'h2);
        bus.eng_done = 3'b010;
        step();
        chk("t1_rel_state", 32'(state_dbg), 32'(RELEASE));
        chk("t1_ack", 32'(bus.ack), 32'h2);
        chk("t1_gnt_rel", 32'(bus.gnt), 32'h0);
        bus.eng_done = '0;
        bus.req = '0;
        step();
        chk("t1_idle", 32'(state_dbg), 32'(IDLE));
        chk("t1_ack_clr", 32'(bus.ack), 32'h0);
        chk("t1_busy_clr", 32'(bus.busy), 32'h0);

        // Pixel forwarding from owner 0, engine 2 must be invisible.
        bus.req = 3'b001;
        step();
        chk("t2_gnt", 32'(bus.gnt), 32'h1);
        step();
        set_pix(0, 159, 119, 5, 1'b1);
        set_pix(2, 7, 3, 2, 1'b1);
        step();
        chk("t2_vga_x", 32'(bus.vga_x), 32'd159);
        chk("t2_vga_y", 32'(bus.vga_y), 32'd119);
        chk("t2_vga_col", 32'(bus.vga_colour), 32'd5);
        chk("t2_vga_plot", 32'(bus.vga_plot), 32'h1);
        set_pix(0, 1, 1, 1, 1'b0);
        bus.eng_done = 3'b100;
        step();
        chk("t2_other_plot", 32'(bus.vga_plot), 32'h0);
        chk("t2_other_x", 32'(bus.vga_x), 32'd1);
        chk("t2_other_done", 32'(state_dbg), 32'(BUSY));
        set_pix(0, 10, 20, 3, 1'b1);
        bus.eng_done = 3'b101;
        step();
        chk("t2_rel_state", 32'(state_dbg), 32'(RELEASE));
        chk("t2_ack", 32'(bus.ack), 32'h1);
        chk("t2_last_plot", 32'(bus.vga_plot), 32'h1);
        chk("t2_last_x", 32'(bus.vga_x), 32'd10);
        chk("t2_last_y", 32'(bus.vga_y), 32'd20);
        chk("t2_last_col", 32'(bus.vga_colour), 32'd3);
        clear_engines();
        bus.req = '0;
        step();
        chk("t2_idle_plot", 32'(bus.vga_plot), 32'h0);

        // Fairness with all requests held, starting from reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            o = n % N;
            w = 0;
            do begin
                step();
                w++;
            end while (bus.eng_start == '0 && w < 20);
            chk("fair_wait", 32'(w), (n == 0) ? 32'd1 : 32'd2);
            chk("fair_gnt", 32'(bus.gnt), 32'(1 << o));
            chk("fair_start", 32'(bus.eng_start), 32'(1 << o));
            repeat (9) step();
            bus.eng_done = 3'(1 << o);
            step();
            chk("fair_ack", 32'(bus.ack), 32'(1 << o));
            bus.eng_done = '0;
        end
        bus.req = '0;
        step();
        step();
        chk("fair_end_gnt", 32'(bus.gnt), 32'h0);
        chk("fair_end_busy", 32'(bus.busy), 32'h0);

        // Request drop during BUSY: owner 2 keeps the port until done.
        bus.req = 3'b100;
        step();
        chk("drop_gnt0", 32'(bus.gnt), 32'h4);
        step();
        bus.req = '0;
        repeat (3) begin
            step();
            chk("drop_gnt", 32'(bus.gnt), 32'h4);
            chk("drop_state", 32'(state_dbg), 32'(BUSY));
        end
        bus.eng_done = 3'b100;
        step();
        chk("drop_ack", 32'(bus.ack), 32'h4);
        bus.eng_done = '0;
        step();
        step();
        chk("drop_no_regnt", 32'(bus.gnt), 32'h0);
        chk("drop_no_start", 32'(bus.eng_start), 32'h0);

        // Reset in the middle of BUSY.
        bus.req = 3'b010;
        step();
        chk("rb_gnt", 32'(bus.gnt), 32'h2);
        step();
        set_pix(1, 50, 60, 6, 1'b1);
        step();
        chk("rb_plot_pre", 32'(bus.vga_plot), 32'h1);
        bus.req = 3'b011;
        rst = 1'b1;
        step();
        chk("rb_gnt_rst", 32'(bus.gnt), 32'h0);
        chk("rb_plot_rst", 32'(bus.vga_plot), 32'h0);
        chk("rb_busy_rst", 32'(bus.busy), 32'h0);
        chk("rb_ack_rst", 32'(bus.ack), 32'h0);
        chk("rb_state_rst", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        set_pix(1, 0, 0, 0, 1'b0);
        step();
        chk("rb_regnt", 32'(bus.gnt), 32'h1);
        chk("rb_ack_none", 32'(bus.ack), 32'h0);
        step();
        bus.eng_done = 3'b001;
        bus.req = '0;
        step();
        chk("rb_ack0", 32'(bus.ack), 32'h1);
        bus.eng_done = '0;
        step();

        // Full-screen fill through engine 1, scoreboarded against exp_q.
        fill_plots = 0;
        fill_bad   = 0;
        fill_dup   = 0;
        bus.req = 3'b010;
        step();
        chk("fill_gnt", 32'(bus.gnt), 32'h2);
        step();
        for (int y = 0; y < SCREEN_H; y++) begin
            for (int x = 0; x < SCREEN_W; x++) begin
                set_pix(1, x, y, y % 8, 1'b1);
                exp_q.push_back({8'(x), 7'(y), 3'(y % 8)});
                if (x == SCREEN_W - 1 && y == SCREEN_H - 1) bus.eng_done = 3'b010;
                step();
                if (bus.vga_plot) begin
                    fill_plots++;
                    got = {bus.vga_x, bus.vga_y, bus.vga_colour};
                    if (exp_q.size() == 0) begin
                        fill_bad++;
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) fill_bad++;
                    end
                    idx = int'(bus.vga_y) * SCREEN_W + int'(bus.vga_x);
                    if (idx < SCREEN_W * SCREEN_H) begin
                        if (covered[idx]) fill_dup++;
                        covered[idx] = 1'b1;
                    end else begin
                        fill_bad++;
                    end
                end
            end
        end
        chk("fill_ack", 32'(bus.ack), 32'h2);
        clear_engines();
        bus.req = '0;
        step();
        chk("fill_idle_plot", 32'(bus.vga_plot), 32'h0);
        fill_missing = 0;
        for (int i = 0; i < SCREEN_W * SCREEN_H; i++) begin
            if (!covered[i]) fill_missing++;
        end
        chk("fill_plots", 32'(fill_plots), 32'd19200);
        chk("fill_data", 32'(fill_bad), 32'd0);
        chk("fill_dup", 32'(fill_dup), 32'd0);
        chk("fill_missing", 32'(fill_missing), 32'd0);
        chk("fill_queue", 32'(exp_q.size()), 32'd0);

        // Final report.
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
